prbs_checker: RTL and testbench

- Receive-side counterpart of the on-chip PRBG: consumes a serial pseudo-random bit stream, self-synchronises a local Fibonacci LFSR to it, then checks every subsequent bit against the local prediction.
- Reports lock status, per-bit error pulses, and saturating bit/error counters.
- Sits at the far end of the serial link, beside the pattern detector, and is used for link BER measurement.

---
 rtl/prbs_checker.sv | 176 +++++++++++++++++
 tb/tb_prbs_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// prbs_checker: receive-side PRBS checker for link BER measurement.
// Self-synchronises a local Fibonacci LFSR to the incoming serial stream.
// Once locked, it flywheels on its own prediction and flags every received
// bit that disagrees with it.
//
// Ports:
//   clk         system clock; all logic acts on the rising edge
//   res         synchronous active-high reset
//   data_in     received serial bit
//   data_valid  data_in is sampled only while high
//   clr_cnt     synchronous clear of bit_count, err_count and lock_lost
//   locked      high while the checker is in the LOCKED state
//   bit_err     one-cycle pulse: the previously sampled bit mismatched while LOCKED
//   err_count   saturating count of errors seen while LOCKED
//   bit_count   saturating count of valid bits seen while LOCKED
//   lock_lost   sticky flag, set on a LOCKED->SEED transition
module prbs_checker #(
    parameter int unsigned      WIDTH    = 7,
    parameter logic [WIDTH-1:0] TAPS     = 7'h60,
    parameter int unsigned      LOCK_CNT = 16,
    parameter int unsigned      WIN      = 64,
    parameter int unsigned      ERR_THR  = 8
) (
    input  logic        clk,
    input  logic        res,
    input  logic        data_in,
    input  logic        data_valid,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        bit_err,
    output logic [15:0] err_count,
    output logic [31:0] bit_count,
    output logic        lock_lost
);

    typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

    localparam logic [4:0] SEED_LAST  = 5'(WIDTH - 1);
    localparam logic [7:0] MATCH_LAST = 8'(LOCK_CNT - 1);
    localparam logic [9:0] WIN_LAST   = 10'(WIN - 1);
    localparam logic [9:0] ERR_LIM    = 10'(ERR_THR);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hist_q, hist_d;
    logic [4:0]       seed_q, seed_d;
    logic [7:0]       match_q, match_d;
    logic [9:0]       wbits_q, wbits_d;
    logic [9:0]       werrs_q, werrs_d;
    logic [15:0]      err_q, err_d;
    logic [31:0]      bits_q, bits_d;
    logic             bit_err_q, bit_err_d;
    logic             lost_q, lost_d;

    logic             pred;
    logic             mism;
    logic             nb;
    logic [9:0]       werrs_inc;

    // State register
    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= SEED;
            hist_q    <= '0;
            seed_q    <= '0;
            match_q   <= '0;
            wbits_q   <= '0;
            werrs_q   <= '0;
            err_q     <= '0;
            bits_q    <= '0;
            bit_err_q <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            seed_q    <= seed_d;
            match_q   <= match_d;
            wbits_q   <= wbits_d;
            werrs_q   <= werrs_d;
            err_q     <= err_d;
            bits_q    <= bits_d;
            bit_err_q <= bit_err_d;
            lost_q    <= lost_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        seed_d    = seed_q;
        match_d   = match_q;
        wbits_d   = wbits_q;
        werrs_d   = werrs_q;
        err_d     = err_q;
        bits_d    = bits_q;
        bit_err_d = 1'b0;
        lost_d    = lost_q;

        pred      = ^(hist_q & TAPS);
        mism      = data_in ^ pred;
        nb        = data_in;
        werrs_inc = werrs_q + {9'b0, mism};

        // Cleared before the FSM runs so that a same-cycle lock loss re-sets it.
        if (clr_cnt) begin
            lost_d = 1'b0;
        end

        if (data_valid) begin
            unique case (state_q)
                SEED: begin
                    seed_d = seed_q + 5'd1;
                    if (seed_q == SEED_LAST) begin
                        state_d = VERIFY;
                        match_d = '0;
                    end
                end
                VERIFY: begin
                    if (mism) begin
                        match_d = '0;
                    end else if (match_q == MATCH_LAST) begin
                        state_d = LOCKED;
                        wbits_d = '0;
                        werrs_d = '0;
                    end else begin
                        match_d = match_q + 8'd1;
                    end
                end
                LOCKED: begin
                    // Flywheel: line errors must not leak into the local sequence.
                    nb = pred;
                    if (bits_q != '1) begin
                        bits_d = bits_q + 32'd1;
                    end
                    if (mism) begin
                        bit_err_d = 1'b1;
                        if (err_q != '1) begin
                            err_d = err_q + 16'd1;
                        end
                    end
                    // The bit that closes a window still has its own error evaluated.
                    if (werrs_inc >= ERR_LIM) begin
                        state_d = SEED;
                        seed_d  = '0;
                        lost_d  = 1'b1;
                    end
                    if (wbits_q == WIN_LAST) begin
                        wbits_d = '0;
                        werrs_d = '0;
                    end else begin
                        wbits_d = wbits_q + 10'd1;
                        werrs_d = werrs_inc;
                    end
                end
                default: state_d = SEED;
            endcase
            hist_d = {hist_q[WIDTH-2:0], nb};
        end

        // A clear beats an increment issued in the same cycle.
        if (clr_cnt) begin
            err_d  = '0;
            bits_d = '0;
        end
    end

    // Output decode
    always_comb begin
        locked    = (state_q == LOCKED);
        bit_err   = bit_err_q;
        err_count = err_q;
        bit_count = bits_q;
        lock_lost = lost_q;
    end

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed self-checking bench for prbs_checker.
// A reference x^7+x^6+1 generator seeded with 7'h7F supplies the line;
// selected bits are inverted to inject errors. A table of stream segments
// with hand-computed end states covers the main flow; hand-written
// sequences cover clear/loss interactions, mid-lock reset and saturation.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        res, res2, din, dv, clr;
    logic        locked, bit_err, lock_lost;
    logic [15:0] err_count;
    logic [31:0] bit_count;
    logic        locked2, bit_err2, lock_lost2;
    logic [15:0] err_count2;
    logic [31:0] bit_count2;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk(clk), .res(res), .data_in(din), .data_valid(dv), .clr_cnt(clr),
        .locked(locked), .bit_err(bit_err), .err_count(err_count),
        .bit_count(bit_count), .lock_lost(lock_lost)
    );

    prbs_checker #(.WIN(64), .ERR_THR(64)) dut2 (
        .clk(clk), .res(res2), .data_in(din), .data_valid(dv), .clr_cnt(clr),
        .locked(locked2), .bit_err(bit_err2), .err_count(err_count2),
        .bit_count(bit_count2), .lock_lost(lock_lost2)
    );

    typedef struct {
        int unsigned nbits;
        int unsigned flip_first;
        int unsigned flip_len;
        bit          gap;
        logic        e_locked;
        logic        e_lost;
        logic [15:0] e_err;
        logic [31:0] e_bits;
        int unsigned e_pulses;
    } seg_t;

    seg_t        tbl[10];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned pulses   = 0;
    int unsigned k2       = 0;
    int unsigned errs2    = 0;
    logic [6:0]  gen_q    = 7'h7F;
    logic        f;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, wait past the edge, count bit_err pulses.
    task automatic drive(input logic v, input logic flip, input logic c);
        logic b;
        b = 1'b0;
        if (v) begin
            b     = gen_q[6] ^ gen_q[5];
            gen_q = {gen_q[5:0], b};
        end
        din = v ? (b ^ flip) : 1'($urandom_range(0, 1));
        dv  = v;
        clr = c;
        @(posedge clk);
        #1;
        if (bit_err) pulses++;
    endtask

    initial begin
        // nbits, flip_first, flip_len, gap, locked, lost, err, bits, pulses
        tbl[0] = '{50, 50, 1, 1'b0, 1'b1, 1'b0, 16'd1,  32'd227, 1};
        tbl[1] = '{40, 40, 1, 1'b0, 1'b1, 1'b0, 16'd2,  32'd267, 1};
        tbl[2] = '{40, 40, 1, 1'b0, 1'b1, 1'b0, 16'd3,  32'd307, 1};
        tbl[3] = '{20,  0, 0, 1'b0, 1'b1, 1'b0, 16'd3,  32'd327, 0};
        tbl[4] = '{ 7,  1, 7, 1'b0, 1'b1, 1'b0, 16'd10, 32'd334, 7};
        tbl[5] = '{ 1,  1, 1, 1'b0, 1'b0, 1'b1, 16'd11, 32'd335, 1};
        tbl[6] = '{22,  0, 0, 1'b0, 1'b0, 1'b1, 16'd11, 32'd335, 0};
        tbl[7] = '{ 1,  0, 0, 1'b0, 1'b1, 1'b1, 16'd11, 32'd335, 0};
        tbl[8] = '{30,  0, 0, 1'b1, 1'b1, 1'b1, 16'd11, 32'd365, 0};
        tbl[9] = '{ 3,  2, 1, 1'b1, 1'b1, 1'b1, 16'd12, 32'd368, 1};

        res = 1'b1; res2 = 1'b1; din = 1'b0; dv = 1'b0; clr = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_bit_err", 32'(bit_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_bit_count", bit_count, 32'd0);
        chk("rst_lock_lost", 32'(lock_lost), 32'd0);
        res   = 1'b0;
        gen_q = 7'h7F;

        // Clean stream: lock appears right after valid bit 23.
        pulses = 0;
        for (int unsigned i = 1; i <= 200; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            if (i == 22) chk("acq_locked_b22", 32'(locked), 32'd0);
            if (i == 23) chk("acq_locked_b23", 32'(locked), 32'd1);
        end
        chk("clean_pulses", pulses, 32'd0);
        chk("clean_bit_count", bit_count, 32'd177);
        chk("clean_err_count", 32'(err_count), 32'd0);
        chk("clean_lock_lost", 32'(lock_lost), 32'd0);

        for (int s = 0; s < 10; s++) begin
            pulses = 0;
            for (int unsigned i = 1; i <= tbl[s].nbits; i++) begin
                f = (i >= tbl[s].flip_first) && (i < tbl[s].flip_first + tbl[s].flip_len);
                drive(1'b1, f, 1'b0);
                if (tbl[s].gap) begin
                    drive(1'b0, 1'b0, 1'b0);
                    drive(1'b0, 1'b0, 1'b0);
                end
            end
            chk($sformatf("seg%0d_locked", s), 32'(locked), 32'(tbl[s].e_locked));
            chk($sformatf("seg%0d_lock_lost", s), 32'(lock_lost), 32'(tbl[s].e_lost));
            chk($sformatf("seg%0d_err_count", s), 32'(err_count), 32'(tbl[s].e_err));
            chk($sformatf("seg%0d_bit_count", s), bit_count, tbl[s].e_bits);
            chk($sformatf("seg%0d_pulses", s), pulses, tbl[s].e_pulses);
        end

        // clr_cnt with an error: counters read 0, lock_lost cleared, pulse still fires.
        drive(1'b1, 1'b1, 1'b1);
        chk("clr_err_count", 32'(err_count), 32'd0);
        chk("clr_bit_count", bit_count, 32'd0);
        chk("clr_lock_lost", 32'(lock_lost), 32'd0);
        chk("clr_bit_err", 32'(bit_err), 32'd1);
        drive(1'b1, 1'b0, 1'b0);
        chk("postclr_bit_count", bit_count, 32'd1);
        chk("postclr_bit_err", 32'(bit_err), 32'd0);
        // Window now holds 2 errors; 5 more stay below threshold, the 6th trips it.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
        chk("pre_loss_locked", 32'(locked), 32'd1);
        chk("pre_loss_err_count", 32'(err_count), 32'd5);
        drive(1'b1, 1'b1, 1'b1);
        chk("clr_loss_locked", 32'(locked), 32'd0);
        chk("clr_loss_lock_lost", 32'(lock_lost), 32'd1);
        chk("clr_loss_err_count", 32'(err_count), 32'd0);

        // Fresh acquisition with gapped valid (1,0,0 repeating).
        res = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        res = 1'b0;
        for (int unsigned i = 1; i <= 23; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
            if (i == 22) chk("gap_locked_b22", 32'(locked), 32'd0);
            drive(1'b0, 1'b0, 1'b0);
        end
        chk("gap_locked_b23", 32'(locked), 32'd1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
        end
        chk("gap_err_count", 32'(err_count), 32'd5);
        chk("gap_bit_count", bit_count, 32'd5);

        // Reset mid-lock overrides a simultaneous valid error bit.
        res = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        res = 1'b0;
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_bit_err", 32'(bit_err), 32'd0);
        chk("midrst_err_count", 32'(err_count), 32'd0);
        chk("midrst_bit_count", bit_count, 32'd0);
        chk("midrst_lock_lost", 32'(lock_lost), 32'd0);
        for (int unsigned i = 1; i <= 23; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            if (i == 22) chk("reacq_locked_b22", 32'(locked), 32'd0);
        end
        chk("reacq_locked_b23", 32'(locked), 32'd1);

        // Saturation on the ERR_THR=WIN instance: 63 errors per 64-bit window.
        res2 = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        res2 = 1'b0;
        for (int i = 0; i < 23; i++) drive(1'b1, 1'b0, 1'b0);
        chk("sat_locked", 32'(locked2), 32'd1);
        while (errs2 < 65535) begin
            k2++;
            f = (k2 % 64) != 0;
            drive(1'b1, f, 1'b0);
            if (f) errs2++;
        end
        chk("sat_err_ffff", 32'(err_count2), 32'h0000_FFFF);
        while (errs2 < 65538) begin
            k2++;
            f = (k2 % 64) != 0;
            drive(1'b1, f, 1'b0);
            if (f) errs2++;
        end
        chk("sat_err_held", 32'(err_count2), 32'h0000_FFFF);
        chk("sat_still_locked", 32'(locked2), 32'd1);
        k2++;
        if ((k2 % 64) == 0) begin
            drive(1'b1, 1'b0, 1'b0);
            k2++;
        end
        drive(1'b1, 1'b1, 1'b1);
        chk("sat_clr_err", 32'(err_count2), 32'd0);
        chk("sat_clr_bit_err", 32'(bit_err2), 32'd1);
        chk("sat_clr_lock_lost", 32'(lock_lost2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
